// File: rtl/ham2d_pkg.sv
// ham2d_pkg: shared constants, FSM state type and code functions for the 2D product-code encoder.
package ham2d_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 15;
    localparam int ROW_K  = 11;
    localparam int ROW_N  = 15;
    localparam int COL_K  = 4;
    localparam int COL_N  = 7;
    localparam int DATA_W = 44;
    localparam int CODE_W = 105;

    typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_e;

    // Bit k is Hamming position k+1; parity at positions 1, 2, 4, 8.
    function automatic logic [ROW_N-1:0] enc1511(input logic [ROW_K-1:0] d);
        logic p1, p2, p4, p8;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        p4 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        p8 = ^d[10:4];
        return {d[10:4], p8, d[3:1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [COL_N-1:0] enc74(input logic [COL_K-1:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    // Row-major 4x15 to column-major 15x4: v[c*4+r] = w[r*15+c].
    function automatic logic [N_ROWS*ROW_N-1:0] interleave60(input logic [N_ROWS*ROW_N-1:0] w);
        logic [N_ROWS*ROW_N-1:0] v;
        v = '0;
        for (int c = 0; c < N_COLS; c++)
            for (int r = 0; r < N_ROWS; r++)
                v[c*N_ROWS+r] = w[r*ROW_N+c];
        return v;
    endfunction

endpackage

// File: rtl/hamming_2d_encoder_if.sv
// hamming_2d_encoder_if: input/output valid-ready channels plus busy status of the 2D encoder.
interface hamming_2d_encoder_if;
    import ham2d_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_data;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/hamming1511_encoder.sv
// hamming1511_encoder: one (15,11) row encoder lane.
module hamming1511_encoder
    import ham2d_pkg::*;
(
    input  logic [ROW_K-1:0] data_i,
    output logic [ROW_N-1:0] code_o
);

    assign code_o = enc1511(data_i);

endmodule

// File: rtl/hamming_2d_encoder.sv
// hamming_2d_encoder: 44-bit word -> 4 rows of (15,11), interleaved, then 15 columns of (7,4) = 105-bit codeword.
// Define HAM2D_ERR_INJECT_EN to add inj_en/inj_pos, which flip one codeword bit during the COL cycle.
module hamming_2d_encoder
    import ham2d_pkg::*;
#(
    parameter int ROW_LANES = 1
) (
    input logic clk,
    input logic rst,
`ifdef HAM2D_ERR_INJECT_EN
    input logic       inj_en,
    input logic [6:0] inj_pos,
`endif
    hamming_2d_encoder_if.slave bus
);

    localparam logic [1:0] CNT_STEP = 2'(ROW_LANES);
    localparam logic [1:0] CNT_LAST = 2'(N_ROWS - ROW_LANES);

    state_e                  state_q;
    logic [1:0]              cnt_q;
    logic [DATA_W-1:0]       data_q;
    logic [N_ROWS*ROW_N-1:0] rows_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic [CODE_W-1:0]       out_data_q;
    logic [CODE_W-1:0]       code_clean;
    logic [CODE_W-1:0]       code_d;
    logic [N_ROWS*ROW_N-1:0] cols;
    logic [1:0]              lane_row  [ROW_LANES];
    logic [ROW_N-1:0]        lane_code [ROW_LANES];

    for (genvar l = 0; l < ROW_LANES; l++) begin : g_lane
        assign lane_row[l] = cnt_q + 2'(l);
        hamming1511_encoder u_enc (
            .data_i(data_q[6'(lane_row[l]) * 6'd11 +: ROW_K]),
            .code_o(lane_code[l])
        );
    end

    assign cols = interleave60(rows_q);

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        assign code_clean[c*COL_N +: COL_N] = enc74(cols[c*COL_K +: COL_K]);
    end

`ifdef HAM2D_ERR_INJECT_EN
    assign code_d = code_clean ^ ((inj_en && inj_pos < 7'(CODE_W)) ? CODE_W'(1) << inj_pos : '0);
`else
    assign code_d = code_clean;
`endif

    // Every row slot is rewritten for each word, so no stale row bits survive into COL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            rows_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    data_q     <= bus.in_data;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= ROW;
                end
                ROW: begin
                    for (int i = 0; i < ROW_LANES; i++)
                        rows_q[6'(lane_row[i]) * 6'd15 +: ROW_N] <= lane_code[i];
                    cnt_q <= cnt_q + CNT_STEP;
                    if (cnt_q == CNT_LAST) state_q <= COL;
                end
                COL: begin
                    out_data_q  <= code_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_hamming_2d_encoder.sv
// tb_hamming_2d_encoder: vector table, lane-count latency, reset abort and random round-trip through a 2D decoder model.
module tb_hamming_2d_encoder;

    typedef struct {
        logic [43:0]  d;
        logic [104:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic inj_en;
    logic [6:0] inj_pos;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hamming_2d_encoder_if b1 ();
    hamming_2d_encoder_if b2 ();
    hamming_2d_encoder_if b4 ();

    hamming_2d_encoder #(.ROW_LANES(1)) u1 (
        .clk(clk),
        .rst(rst),
`ifdef HAM2D_ERR_INJECT_EN
        .inj_en(inj_en),
        .inj_pos(inj_pos),
`endif
        .bus(b1)
    );

    hamming_2d_encoder #(.ROW_LANES(2)) u2 (
        .clk(clk),
        .rst(rst),
`ifdef HAM2D_ERR_INJECT_EN
        .inj_en(1'b0),
        .inj_pos(7'd0),
`endif
        .bus(b2)
    );

    hamming_2d_encoder #(.ROW_LANES(4)) u4 (
        .clk(clk),
        .rst(rst),
`ifdef HAM2D_ERR_INJECT_EN
        .inj_en(1'b0),
        .inj_pos(7'd0),
`endif
        .bus(b4)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Generic single-error-correcting Hamming decode: syndrome is the XOR of set-bit positions.
    function automatic logic [10:0] dec_ham(input logic [14:0] cw, input int n, output logic err);
        int syn;
        int k;
        logic [10:0] d;
        syn = 0;
        k = 0;
        d = '0;
        for (int p = 1; p <= n; p++) if (cw[p-1]) syn ^= p;
        err = (syn != 0);
        if (err && syn <= n) cw[syn-1] = ~cw[syn-1];
        for (int p = 1; p <= n; p++)
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p-1];
                k++;
            end
        return d;
    endfunction

    function automatic logic [43:0] decode2d(input logic [104:0] cw, output logic err);
        logic [59:0] w;
        logic [43:0] d;
        logic [10:0] t;
        logic e;
        err = 1'b0;
        w = '0;
        d = '0;
        for (int c = 0; c < 15; c++) begin
            t = dec_ham(15'(cw[c*7 +: 7]), 7, e);
            err |= e;
            for (int r = 0; r < 4; r++) w[r*15+c] = t[r];
        end
        for (int r = 0; r < 4; r++) begin
            t = dec_ham(w[r*15 +: 15], 15, e);
            err |= e;
            d[r*11 +: 11] = t;
        end
        return d;
    endfunction

    // Feed one word to all three lane variants at once (all idle, out_ready high) and time each.
    task automatic lock_word(input logic [43:0] d, output logic [104:0] o1, output logic [104:0] o2,
                             output logic [104:0] o4, output int l1, output int l2, output int l4,
                             output logic r1);
        o1 = '0; o2 = '0; o4 = '0;
        l1 = 0; l2 = 0; l4 = 0;
        r1 = 1'b0;
        b1.in_valid = 1'b1; b2.in_valid = 1'b1; b4.in_valid = 1'b1;
        b1.in_data = d; b2.in_data = d; b4.in_data = d;
        @(posedge clk); #1;
        b1.in_valid = 1'b0; b2.in_valid = 1'b0; b4.in_valid = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (l1 != 0 && cyc == l1 + 1) r1 = b1.in_ready;
            if (l1 == 0 && b1.out_valid) begin l1 = cyc; o1 = b1.out_data; end
            if (l2 == 0 && b2.out_valid) begin l2 = cyc; o2 = b2.out_data; end
            if (l4 == 0 && b4.out_valid) begin l4 = cyc; o4 = b4.out_data; end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [4];
        logic [104:0] o1, o2, o4, o, prev;
        logic [43:0] d, dec;
        logic e, r1, done, stalled, rdy_ok, stable_ok;
        int l1, l2, l4, nv, gap;

        tv[0] = '{44'h0, 105'h0};
        tv[1] = '{44'h1, 105'h1C387};
        tv[2] = '{{44{1'b1}}, {105{1'b1}}};
        tv[3] = '{44'h800_0000_0000, (105'h4B) | (105'h4B << 7) | (105'h4B << 21) | (105'h4B << 49) | (105'h4B << 98)};

        rst = 1'b1;
        inj_en = 1'b0;
        inj_pos = 7'd0;
        b1.in_valid = 1'b0; b2.in_valid = 1'b0; b4.in_valid = 1'b0;
        b1.in_data = '0; b2.in_data = '0; b4.in_data = '0;
        b1.out_ready = 1'b1; b2.out_ready = 1'b1; b4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(b1.in_ready), 128'(1));
        check("rst_out_valid", 128'(b1.out_valid), 128'(0));
        check("rst_out_data", 128'(b1.out_data), 128'(0));
        check("rst_busy", 128'(b1.busy), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            lock_word(tv[i].d, o1, o2, o4, l1, l2, l4, r1);
            check($sformatf("vec%0d_lanes1", i), 128'(o1), 128'(tv[i].exp));
            check($sformatf("vec%0d_lanes2", i), 128'(o2), 128'(tv[i].exp));
            check($sformatf("vec%0d_lanes4", i), 128'(o4), 128'(tv[i].exp));
            check($sformatf("vec%0d_lat1", i), 128'(l1), 128'(6));
            check($sformatf("vec%0d_lat2", i), 128'(l2), 128'(4));
            check($sformatf("vec%0d_lat4", i), 128'(l4), 128'(3));
            check($sformatf("vec%0d_ready_after_out", i), 128'(r1), 128'(1));
        end

        // Reset during the second ROW cycle must abort the word.
        b1.in_valid = 1'b1;
        b1.in_data = 44'hABC_DEF0_1234;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        @(posedge clk); #2;
        check("abort_busy_before", 128'(b1.busy), 128'(1));
        rst = 1'b1;
        #1;
        check("abort_busy_async", 128'(b1.busy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (b1.out_valid) nv++;
        end
        check("abort_no_output", 128'(nv), 128'(0));
        check("abort_in_ready", 128'(b1.in_ready), 128'(1));
        @(posedge clk); #1;
        lock_word(44'h123_4567_89AB, o1, o2, o4, l1, l2, l4, r1);
        dec = decode2d(o1, e);
        check("after_abort_decode", 128'(dec), 128'(44'h123_4567_89AB));
        check("after_abort_err", 128'(e), 128'(0));
        check("after_abort_lanes_agree", 128'(o1), 128'(o4));

        for (int i = 0; i < 1000; i++) begin
            d = {12'($urandom), 32'($urandom)};
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            b1.in_valid = 1'b1;
            b1.in_data = d;
            @(posedge clk); #1;
            b1.in_valid = 1'b0;
            done = 1'b0; stalled = 1'b0; rdy_ok = 1'b1; stable_ok = 1'b1;
            o = '0; prev = '0;
            for (int cyc = 0; cyc < 64 && !done; cyc++) begin
                b1.in_data = {12'($urandom), 32'($urandom)};
                @(negedge clk);
                if (b1.in_ready) rdy_ok = 1'b0;
                if (b1.out_valid) begin
                    if (stalled && b1.out_data !== prev) stable_ok = 1'b0;
                    o = b1.out_data;
                    prev = o;
                    b1.out_ready = ($urandom_range(0, 2) != 0);
                    stalled = !b1.out_ready;
                    done = b1.out_ready;
                end
                @(posedge clk); #1;
            end
            dec = decode2d(o, e);
            check("rnd_done", 128'(done), 128'(1));
            check("rnd_decode", 128'(dec), 128'(d));
            check("rnd_err", 128'(e), 128'(0));
            check("rnd_in_ready_low", 128'(rdy_ok), 128'(1));
            check("rnd_stall_stable", 128'(stable_ok), 128'(1));
        end
        b1.out_ready = 1'b1;

`ifdef HAM2D_ERR_INJECT_EN
        inj_en = 1'b1;
        inj_pos = 7'd52;
        lock_word(44'h5A5_A5A5_A5A5, o1, o2, o4, l1, l2, l4, r1);
        check("inj52_diff", 128'(o1 ^ o2), 128'(105'(1) << 52));
        dec = decode2d(o1, e);
        check("inj52_decode", 128'(dec), 128'(44'h5A5_A5A5_A5A5));
        inj_pos = 7'd110;
        lock_word(44'h0F0_F0F0_F0F0, o1, o2, o4, l1, l2, l4, r1);
        check("inj110_diff", 128'(o1 ^ o2), 128'(0));
        inj_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
